// File: rtl/clock_gen_multi_pkg.sv
// Shared types, reset defaults and config clamping rules for the multi-channel
// clock/strobe generator.
package clock_gen_multi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } ch_state_e;

    localparam int unsigned DEF_PERIOD = 10;
    localparam int unsigned DEF_HIGH   = 5;
    localparam int unsigned MIN_PERIOD = 2;

    // A period below two cycles cannot hold both a high and a low phase.
    function automatic int unsigned clamp_period(input int unsigned period);
        return (period < MIN_PERIOD) ? MIN_PERIOD : period;
    endfunction

    // High count is kept in [1, period-1] so the output always toggles.
    function automatic int unsigned clamp_high(input int unsigned high,
                                               input int unsigned period);
        if (high == 0) begin
            return 1;
        end
        if (high >= period) begin
            return period - 1;
        end
        return high;
    endfunction

endpackage

// File: rtl/clock_gen_multi_if.sv
// Run-request, config-write and divided-clock signals of clock_gen_multi.
// The slave side is the generator, the master side drives it.
interface clock_gen_multi_if #(
    parameter int NCH      = 4,
    parameter int PERIOD_W = 16
) ();
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0]      ENABLE;
    logic                CFG_VALID;
    logic                CFG_READY;
    logic [CH_W-1:0]     CFG_CH;
    logic [PERIOD_W-1:0] CFG_PERIOD;
    logic [PERIOD_W-1:0] CFG_HIGH;
    logic [NCH-1:0]      CLK_OUT;
    logic [NCH-1:0]      TICK;
    logic [NCH-1:0]      BUSY;

    modport master (
        output ENABLE, CFG_VALID, CFG_CH, CFG_PERIOD, CFG_HIGH,
        input  CFG_READY, CLK_OUT, TICK, BUSY
    );

    modport slave (
        input  ENABLE, CFG_VALID, CFG_CH, CFG_PERIOD, CFG_HIGH,
        output CFG_READY, CLK_OUT, TICK, BUSY
    );

endinterface

// File: rtl/clock_gen_multi_channel.sv
// One divider channel: run/drain FSM, phase counter and a shadowed period/high
// pair that is only swapped in on a period boundary.
module clock_gen_multi_channel
    import clock_gen_multi_pkg::*;
#(
    parameter int PERIOD_W   = 16,
    parameter int RST_PERIOD = 10,
    parameter int RST_HIGH   = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                cfg_we,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic [PERIOD_W-1:0] cfg_high,
    output logic                clk_out,
    output logic                tick,
    output logic                busy,
    output logic                pending
);

    ch_state_e           state_q, state_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] high_q, high_d;
    logic                pending_q, pending_d;
    logic [PERIOD_W-1:0] shadow_period_q, shadow_period_d;
    logic [PERIOD_W-1:0] shadow_high_q, shadow_high_d;

    logic                wrap;
    logic                apply;
    logic [PERIOD_W-1:0] period_new;
    logic [PERIOD_W-1:0] high_new;

    assign wrap       = (cnt_q == (period_q - PERIOD_W'(1)));
    assign period_new = PERIOD_W'(clamp_period(32'(shadow_period_q)));
    assign high_new   = PERIOD_W'(clamp_high(32'(shadow_high_q), 32'(period_new)));

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        period_d        = period_q;
        high_d          = high_q;
        pending_d       = pending_q;
        shadow_period_d = shadow_period_q;
        shadow_high_d   = shadow_high_q;
        apply           = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                apply = pending_q;
                if (en) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN, ST_DRAIN: begin
                // Disabling only takes effect at the end of a full period, so
                // the last pulse is never truncated.
                if (wrap) begin
                    cnt_d   = '0;
                    apply   = pending_q;
                    state_d = en ? ST_RUN : ST_IDLE;
                end else begin
                    cnt_d   = cnt_q + PERIOD_W'(1);
                    state_d = en ? ST_RUN : ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (apply) begin
            period_d  = period_new;
            high_d    = high_new;
            pending_d = 1'b0;
        end

        // Writes are only accepted while nothing is pending, so they can never
        // collide with an apply in the same cycle.
        if (cfg_we) begin
            pending_d       = 1'b1;
            shadow_period_d = cfg_period;
            shadow_high_d   = cfg_high;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            period_q  <= PERIOD_W'(RST_PERIOD);
            high_q    <= PERIOD_W'(RST_HIGH);
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            high_q    <= high_d;
            pending_q <= pending_d;
        end
    end

    // Shadow contents are only consumed while pending is set.
    always_ff @(posedge clk) begin
        shadow_period_q <= shadow_period_d;
        shadow_high_q   <= shadow_high_d;
    end

    assign busy    = (state_q != ST_IDLE);
    assign clk_out = busy && (cnt_q < high_q);
    assign tick    = busy && (cnt_q == '0);
    assign pending = pending_q;

endmodule

// File: rtl/clock_gen_multi.sv
// N-channel programmable clock/strobe generator: per-channel dividers with a
// shared config write port steered by CFG_CH.
module clock_gen_multi #(
    parameter int NCH        = 4,
    parameter int PERIOD_W   = 16,
    parameter int DEF_PERIOD = int'(clock_gen_multi_pkg::DEF_PERIOD),
    parameter int DEF_HIGH   = int'(clock_gen_multi_pkg::DEF_HIGH)
) (
    input  logic           CLOCK,
    input  logic           RESET,
    clock_gen_multi_if.slave bus
);

    localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CH_SPAN = 1 << CH_W;

    logic [NCH-1:0]     pending;
    logic [NCH-1:0]     cfg_we;
    logic [NCH-1:0]     clk_out;
    logic [NCH-1:0]     tick;
    logic [NCH-1:0]     busy;
    logic [CH_SPAN-1:0] pending_ext;
    logic               cfg_ready;

    // Channel numbers beyond NCH read as ready and address nothing.
    always_comb begin
        pending_ext          = '0;
        pending_ext[NCH-1:0] = pending;
    end

    assign cfg_ready = ~pending_ext[bus.CFG_CH];

    always_comb begin
        cfg_we = '0;
        for (int i = 0; i < NCH; i++) begin
            if (bus.CFG_VALID && cfg_ready && (bus.CFG_CH == CH_W'(i))) begin
                cfg_we[i] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        clock_gen_multi_channel #(
            .PERIOD_W  (PERIOD_W),
            .RST_PERIOD(DEF_PERIOD),
            .RST_HIGH  (DEF_HIGH)
        ) u_ch (
            .clk       (CLOCK),
            .rst       (RESET),
            .en        (bus.ENABLE[g]),
            .cfg_we    (cfg_we[g]),
            .cfg_period(bus.CFG_PERIOD),
            .cfg_high  (bus.CFG_HIGH),
            .clk_out   (clk_out[g]),
            .tick      (tick[g]),
            .busy      (busy[g]),
            .pending   (pending[g])
        );
    end

    assign bus.CFG_READY = cfg_ready;
    assign bus.CLK_OUT   = clk_out;
    assign bus.TICK      = tick;
    assign bus.BUSY      = busy;

endmodule

// File: tb/tb_clock_gen_multi.sv
// Bench for clock_gen_multi: period-start model checked every cycle, plus
// directed waveform captures with hand-computed bit patterns.
module tb_clock_gen_multi;

    localparam int NCH = 4;
    localparam int PW  = 16;
    localparam int DP  = 10;
    localparam int DH  = 5;

    logic CLOCK = 1'b0;
    logic RESET = 1'b1;

    clock_gen_multi_if #(.NCH(NCH), .PERIOD_W(PW)) bus ();

    clock_gen_multi #(
        .NCH       (NCH),
        .PERIOD_W  (PW),
        .DEF_PERIOD(DP),
        .DEF_HIGH  (DH)
    ) dut (
        .CLOCK(CLOCK),
        .RESET(RESET),
        .bus  (bus)
    );

    always #5 CLOCK = ~CLOCK;

    int errors = 0;
    int checks = 0;
    bit done   = 1'b0;

    // Model: each busy channel remembers the cycle its current period began.
    bit m_ok = 1'b0;
    int m_cyc = 0;
    bit m_busy [NCH];
    int m_start[NCH];
    int m_per  [NCH];
    int m_hi   [NCH];
    bit m_pend [NCH];
    int m_sper [NCH];
    int m_shi  [NCH];

    always @(posedge CLOCK) begin : model
        bit endp, appl, acc;
        for (int c = 0; c < NCH; c++) begin
            if (RESET) begin
                m_busy[c]  = 1'b0;
                m_start[c] = 0;
                m_per[c]   = DP;
                m_hi[c]    = DH;
                m_pend[c]  = 1'b0;
            end else begin
                endp = m_busy[c] && ((m_cyc - m_start[c]) == m_per[c] - 1);
                appl = m_pend[c] && (!m_busy[c] || endp);
                acc  = bus.CFG_VALID && (int'(bus.CFG_CH) == c) && !m_pend[c];
                if (!m_busy[c]) begin
                    if (bus.ENABLE[c]) begin
                        m_busy[c]  = 1'b1;
                        m_start[c] = m_cyc + 1;
                    end
                end else if (endp) begin
                    if (bus.ENABLE[c]) m_start[c] = m_cyc + 1;
                    else m_busy[c] = 1'b0;
                end
                if (appl) begin
                    m_per[c]  = (m_sper[c] < 2) ? 2 : m_sper[c];
                    m_hi[c]   = (m_shi[c] == 0) ? 1 :
                                (m_shi[c] >= m_per[c]) ? m_per[c] - 1 : m_shi[c];
                    m_pend[c] = 1'b0;
                end
                if (acc) begin
                    m_pend[c] = 1'b1;
                    m_sper[c] = int'(bus.CFG_PERIOD);
                    m_shi[c]  = int'(bus.CFG_HIGH);
                end
            end
        end
        if (RESET) m_ok = 1'b1;
        m_cyc = m_cyc + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_cycle();
        logic [NCH-1:0] e_clk, e_tick, e_busy;
        logic           e_rdy;
        int             pos;
        for (int c = 0; c < NCH; c++) begin
            pos       = m_cyc - m_start[c];
            e_busy[c] = m_busy[c];
            e_clk[c]  = m_busy[c] && (pos < m_hi[c]);
            e_tick[c] = m_busy[c] && (pos == 0);
        end
        e_rdy = !m_pend[bus.CFG_CH];
        chk("cyc_clk_out", 64'(bus.CLK_OUT), 64'(e_clk));
        chk("cyc_tick", 64'(bus.TICK), 64'(e_tick));
        chk("cyc_busy", 64'(bus.BUSY), 64'(e_busy));
        chk("cyc_cfg_ready", 64'(bus.CFG_READY), 64'(e_rdy));
    endtask

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic capture(input int ch, input int n,
                           output logic [63:0] cv, output logic [63:0] tv,
                           output logic [63:0] bv, output logic [63:0] rv);
        cv = '0; tv = '0; bv = '0; rv = '0;
        for (int i = 0; i < n; i++) begin
            #1;
            cv[i] = bus.CLK_OUT[ch];
            tv[i] = bus.TICK[ch];
            bv[i] = bus.BUSY[ch];
            rv[i] = bus.CFG_READY;
            step();
        end
    endtask

    task automatic cfg_drive(input int ch, input int per, input int hi);
        bus.CFG_VALID  = 1'b1;
        bus.CFG_CH     = 2'(ch);
        bus.CFG_PERIOD = PW'(per);
        bus.CFG_HIGH   = PW'(hi);
    endtask

    logic [63:0] cv, tv, bv, rv;
    int per_tab [NCH] = '{2, 3, 5, 16};
    int hi_tab  [NCH] = '{1, 1, 2, 8};
    int exp_tk  [NCH] = '{120, 80, 48, 15};
    int tick_cnt[NCH];

    initial begin
        bus.ENABLE     = '0;
        bus.CFG_VALID  = 1'b0;
        bus.CFG_CH     = '0;
        bus.CFG_PERIOD = '0;
        bus.CFG_HIGH   = '0;
        fork
            while (!done) begin
                @(negedge CLOCK);
                if (m_ok && !done) compare_cycle();
            end
            begin
                step(); step();
                RESET = 1'b0;
                #1;
                chk("rst_clk_out", 64'(bus.CLK_OUT), 64'h0);
                chk("rst_tick", 64'(bus.TICK), 64'h0);
                chk("rst_busy", 64'(bus.BUSY), 64'h0);
                chk("rst_cfg_ready", 64'(bus.CFG_READY), 64'h1);

                // Default divide on channel 0: 5 high / 5 low, tick every 10.
                bus.ENABLE = 4'b0001;
                step();
                capture(0, 20, cv, tv, bv, rv);
                chk("t1_clk", cv, 64'h7C1F);
                chk("t1_tick", tv, 64'h00401);
                chk("t1_busy", bv, 64'hFFFFF);

                // Reprogram running channel 1 at cnt=3.
                bus.ENABLE[1] = 1'b1;
                step(); step(); step(); step();
                cfg_drive(1, 7, 2);
                #1;
                chk("t2_ready_before", 64'(bus.CFG_READY), 64'h1);
                step();
                bus.CFG_VALID = 1'b0;
                capture(1, 20, cv, tv, bv, rv);
                chk("t2_clk", cv, 64'h060C1);
                chk("t2_tick", tv, 64'h02040);
                chk("t2_ready", rv, 64'hFFFC0);

                // Clamping on idle channel 3, then on a running one.
                cfg_drive(3, 1, 0);
                step();
                bus.CFG_VALID = 1'b0;
                #1;
                chk("t3_ready_pending", 64'(bus.CFG_READY), 64'h0);
                step();
                chk("t3_ready_applied", 64'(bus.CFG_READY), 64'h1);
                bus.ENABLE[3] = 1'b1;
                step();
                capture(3, 8, cv, tv, bv, rv);
                chk("t3_clk_p2", cv, 64'h55);
                chk("t3_tick_p2", tv, 64'h55);
                cfg_drive(3, 4, 9);
                step();
                bus.CFG_VALID = 1'b0;
                step();
                capture(3, 8, cv, tv, bv, rv);
                chk("t3_clk_p4", cv, 64'h77);
                chk("t3_tick_p4", tv, 64'h11);

                // Drop channel 2 at cnt=3, then re-enable inside a drain.
                bus.ENABLE[2] = 1'b1;
                step(); step(); step(); step();
                bus.ENABLE[2] = 1'b0;
                capture(2, 10, cv, tv, bv, rv);
                chk("t4_drain_clk", cv, 64'h003);
                chk("t4_drain_busy", bv, 64'h07F);
                chk("t4_drain_tick", tv, 64'h000);
                bus.ENABLE[2] = 1'b1;
                step(); step(); step();
                bus.ENABLE[2] = 1'b0;
                step(); step(); step();
                bus.ENABLE[2] = 1'b1;
                capture(2, 15, cv, tv, bv, rv);
                chk("t4_reen_clk", cv, 64'h03E0);
                chk("t4_reen_tick", tv, 64'h0020);
                chk("t4_reen_busy", bv, 64'h7FFF);

                // Reset while all run with a config pending on channel 0.
                bus.ENABLE = 4'hF;
                repeat (22) step();
                cfg_drive(0, 3, 1);
                step();
                bus.CFG_VALID = 1'b0;
                #1;
                chk("t5_ready_pending", 64'(bus.CFG_READY), 64'h0);
                RESET = 1'b1;
                step();
                chk("t5_clk_out", 64'(bus.CLK_OUT), 64'h0);
                chk("t5_tick", 64'(bus.TICK), 64'h0);
                chk("t5_busy", 64'(bus.BUSY), 64'h0);
                chk("t5_ready", 64'(bus.CFG_READY), 64'h1);
                RESET = 1'b0;
                step();
                capture(0, 10, cv, tv, bv, rv);
                chk("t5_def_clk", cv, 64'h01F);
                chk("t5_def_tick", tv, 64'h001);
                chk("t5_def_ready", rv, 64'h3FF);

                // Four different periods, back-to-back writes, tick counts.
                bus.ENABLE = 4'h0;
                repeat (12) step();
                chk("t6_idle", 64'(bus.BUSY), 64'h0);
                for (int c = 0; c < NCH; c++) begin
                    cfg_drive(c, per_tab[c], hi_tab[c]);
                    #1;
                    chk("t6_ready_wr", 64'(bus.CFG_READY), 64'h1);
                    step();
                end
                bus.CFG_VALID = 1'b0;
                step();
                bus.ENABLE = 4'hF;
                step();
                for (int c = 0; c < NCH; c++) tick_cnt[c] = 0;
                for (int i = 0; i < 240; i++) begin
                    #1;
                    for (int c = 0; c < NCH; c++) begin
                        if (bus.TICK[c]) tick_cnt[c]++;
                    end
                    step();
                end
                for (int c = 0; c < NCH; c++) begin
                    chk($sformatf("t6_ticks_ch%0d", c), 64'(tick_cnt[c]), 64'(exp_tk[c]));
                end
                done = 1'b1;
            end
        join
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
